// File: rtl/pipeline_pkg.sv
// Shared opcodes, NOP encoding and hazard FSM state type for the RV32I pipeline.
package pipeline_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {RUN, MULDIV_WAIT} hz_state_t;

endpackage

// File: rtl/operand_use_decode.sv
// Decodes which source registers the instruction in IF/ID actually reads.
// x0 is reported as unused so it can never raise a hazard.
module operand_use_decode
  import pipeline_pkg::*;
(
  input  logic [31:0] i_instruction,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic        o_use_rs1,
  output logic        o_use_rs2
);

  logic [6:0] w_opcode;

  assign w_opcode = i_instruction[6:0];
  assign o_rs1    = i_instruction[19:15];
  assign o_rs2    = i_instruction[24:20];

  // rs1 is read by everything except the U-type ops and JAL; rs2 only by R/S/B formats.
  assign o_use_rs1 = !(w_opcode inside {OP_LUI, OP_AUIPC, OP_JAL}) && (o_rs1 != 5'd0);
  assign o_use_rs2 = (w_opcode inside {OP_R, OP_STORE, OP_BRANCH}) && (o_rs2 != 5'd0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall / flush / redirect controller for the 5-stage core, with stall and
// redirect performance counters. Control outputs are combinational.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MULDIV_LATENCY = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] ifid_instruction,
  input  logic        ifid_valid,
  input  logic [4:0]  idex_rd,
  input  logic        idex_mem_read,
  input  logic        idex_valid,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_muldiv_start,
  input  logic        dmem_busy,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        stall_idex,
  output logic        stall_exmem,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        flush_exmem,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_redirects
);

  localparam logic [7:0] CntLoad = 8'(MULDIV_LATENCY - 1);

  hz_state_t   r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_redir;

  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_lu;
  logic        w_md;

  operand_use_decode u_decode (
    .i_instruction (ifid_instruction),
    .o_rs1         (w_rs1),
    .o_rs2         (w_rs2),
    .o_use_rs1     (w_use_rs1),
    .o_use_rs2     (w_use_rs2)
  );

  assign w_lu = idex_valid && idex_mem_read && (idex_rd != 5'd0) && ifid_valid &&
                ((w_use_rs1 && (w_rs1 == idex_rd)) || (w_use_rs2 && (w_rs2 == idex_rd)));

  // The start cycle itself already occupies EX, so it counts as mul/div busy.
  assign w_md = ((r_state == RUN) && ex_muldiv_start) || (r_state == MULDIV_WAIT);

  assign redirect_pc       = ex_target;
  assign perf_stall_cycles = r_perf_stall;
  assign perf_redirects    = r_perf_redir;

  // Priority-encoded controls; everything forced low while reset is held.
  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    pc_redirect = 1'b0;
    if (resetn) begin
      if (dmem_busy) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        stall_exmem = 1'b1;
      end else if (w_md) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        flush_exmem = 1'b1;
      end else if (ex_branch_taken) begin
        pc_redirect = 1'b1;
        flush_ifid  = 1'b1;
        flush_idex  = 1'b1;
      end else if (w_lu) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        flush_idex  = 1'b1;
      end
    end
  end

  // Mul/div occupancy FSM; keeps counting even while dmem_busy holds the pipe.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= RUN;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (ex_muldiv_start) begin
            r_state <= MULDIV_WAIT;
            r_cnt   <= CntLoad;
          end
        end
        MULDIV_WAIT: begin
          if (r_cnt == 8'd1) begin
            r_state <= RUN;
          end
          r_cnt <= r_cnt - 8'd1;
        end
        default: begin
          r_state <= RUN;
          r_cnt   <= 8'd0;
        end
      endcase
    end
  end

  // Free-running wrap-around performance counters.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_perf_stall <= 32'd0;
      r_perf_redir <= 32'd0;
    end else begin
      if (stall_pc) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (pc_redirect) begin
        r_perf_redir <= r_perf_redir + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised + directed bench for pipeline_hazard_ctrl with a queue scoreboard.
module tb_pipeline_hazard_ctrl;
  import pipeline_pkg::*;

  localparam int unsigned Lat = 4;

  logic        clock;
  logic        resetn;
  logic [31:0] ifid_instruction;
  logic        ifid_valid;
  logic [4:0]  idex_rd;
  logic        idex_mem_read;
  logic        idex_valid;
  logic        ex_branch_taken;
  logic [31:0] ex_target;
  logic        ex_muldiv_start;
  logic        dmem_busy;
  logic        stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic        flush_ifid, flush_idex, flush_exmem, pc_redirect;
  logic [31:0] redirect_pc, perf_stall_cycles, perf_redirects;

  pipeline_hazard_ctrl #(.MULDIV_LATENCY(Lat)) dut (
    .clock             (clock),
    .resetn            (resetn),
    .ifid_instruction  (ifid_instruction),
    .ifid_valid        (ifid_valid),
    .idex_rd           (idex_rd),
    .idex_mem_read     (idex_mem_read),
    .idex_valid        (idex_valid),
    .ex_branch_taken   (ex_branch_taken),
    .ex_target         (ex_target),
    .ex_muldiv_start   (ex_muldiv_start),
    .dmem_busy         (dmem_busy),
    .stall_pc          (stall_pc),
    .stall_ifid        (stall_ifid),
    .stall_idex        (stall_idex),
    .stall_exmem       (stall_exmem),
    .flush_ifid        (flush_ifid),
    .flush_idex        (flush_idex),
    .flush_exmem       (flush_exmem),
    .pc_redirect       (pc_redirect),
    .redirect_pc       (redirect_pc),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_redirects    (perf_redirects)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {pc_redirect, stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex, flush_exmem}
  typedef struct packed {
    logic [7:0]  ctl;
    logic [31:0] rpc;
    logic [31:0] pst;
    logic [31:0] prd;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Reference model: remaining mul/div stall cycles after the current one, plus counters.
  int          md_left = 0;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_redir = 32'd0;

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction

  function automatic logic [7:0] model_ctl();
    logic [6:0] op;
    logic       u1, u2, lu, md;
    op = ifid_instruction[6:0];
    u1 = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    u2 = (op == OP_R || op == OP_STORE || op == OP_BRANCH);
    lu = idex_valid && idex_mem_read && idex_rd != 0 && ifid_valid &&
         ((u1 && ifid_instruction[19:15] == idex_rd) ||
          (u2 && ifid_instruction[24:20] == idex_rd));
    md = (md_left > 0) || ex_muldiv_start;
    if (!resetn)              return 8'b0000_0000;
    else if (dmem_busy)       return 8'b0111_1000;
    else if (md)              return 8'b0111_0001;
    else if (ex_branch_taken) return 8'b1000_0110;
    else if (lu)              return 8'b0110_0010;
    else                      return 8'b0000_0000;
  endfunction

  // Push expectation for the current inputs, then advance the model across the edge.
  task automatic step();
    exp_t e;
    e.ctl = model_ctl();
    e.rpc = ex_target;
    e.pst = resetn ? m_stall : 32'd0;
    e.prd = resetn ? m_redir : 32'd0;
    sb.push_back(e);
    @(posedge clock);
    if (!resetn) begin
      md_left = 0;
      m_stall = 32'd0;
      m_redir = 32'd0;
    end else begin
      if (e.ctl[6]) m_stall = m_stall + 32'd1;
      if (e.ctl[7]) m_redir = m_redir + 32'd1;
      if (md_left > 0) md_left = md_left - 1;
      else if (ex_muldiv_start) md_left = Lat - 1;
    end
    #1;
  endtask

  task automatic idle();
    ifid_instruction = NOP_INSTR;
    ifid_valid       = 1'b0;
    idex_rd          = 5'd0;
    idex_mem_read    = 1'b0;
    idex_valid       = 1'b0;
    ex_branch_taken  = 1'b0;
    ex_muldiv_start  = 1'b0;
    dmem_busy        = 1'b0;
  endtask

  task automatic set_lw5(input logic [31:0] ifid);
    idex_rd = 5'd5; idex_mem_read = 1'b1; idex_valid = 1'b1;
    ifid_instruction = ifid; ifid_valid = 1'b1;
  endtask

  // Monitor: control outputs are valid every cycle, so one pop per falling edge.
  always @(negedge clock) begin
    exp_t e;
    logic [7:0] act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {pc_redirect, stall_pc, stall_ifid, stall_idex, stall_exmem,
             flush_ifid, flush_idex, flush_exmem};
      n_tests++;
      if (act !== e.ctl || redirect_pc !== e.rpc) begin
        n_fail++;
        $display("FAIL ctl t=%0t actual=%b/%h required=%b/%h", $time, act, redirect_pc,
                 e.ctl, e.rpc);
      end
      n_tests++;
      if (perf_stall_cycles !== e.pst || perf_redirects !== e.prd) begin
        n_fail++;
        $display("FAIL perf t=%0t actual=%0d/%0d required=%0d/%0d", $time,
                 perf_stall_cycles, perf_redirects, e.pst, e.prd);
      end
    end
  end

  initial begin
    logic [6:0] ops [8];
    ops[0] = OP_LUI; ops[1] = OP_AUIPC; ops[2] = OP_JAL; ops[3] = OP_R;
    ops[4] = OP_STORE; ops[5] = OP_BRANCH; ops[6] = OP_LOAD; ops[7] = 7'b0010011;
    idle();
    ex_target = 32'd0;
    resetn    = 1'b0;
    @(posedge clock); #1;
    step(); step();
    resetn = 1'b1;
    step();

    // Load-use: LW x5 then ADD x6,x5,x7.
    set_lw5(32'h0072_8333); step();
    idle(); step();
    // No false hazards.
    idex_rd = 5'd0; idex_mem_read = 1'b1; idex_valid = 1'b1;
    ifid_instruction = mk(OP_R, 5'd6, 5'd0, 5'd0); ifid_valid = 1'b1; step();
    set_lw5(mk(OP_LUI, 5'd5, 5'd5, 5'd5)); step();
    set_lw5(mk(7'b0010011, 5'd6, 5'd1, 5'd5)); step();
    // Taken branch over a live load-use.
    set_lw5(32'h0072_8333); ex_branch_taken = 1'b1; ex_target = 32'h0000_0100; step();
    idle(); step();
    // Mul/div alone.
    ex_muldiv_start = 1'b1; step();
    ex_muldiv_start = 1'b0; repeat (5) step();
    // Mul/div with dmem_busy from its 2nd cycle for 3 cycles.
    ex_muldiv_start = 1'b1; step();
    ex_muldiv_start = 1'b0; dmem_busy = 1'b1; repeat (3) step();
    dmem_busy = 1'b0; repeat (2) step();
    // Reset in the middle of MULDIV_WAIT.
    ex_muldiv_start = 1'b1; step();
    ex_muldiv_start = 1'b0; step();
    resetn = 1'b0; step(); step();
    resetn = 1'b1; repeat (2) step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      ifid_instruction = mk(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      ifid_valid      = ($urandom_range(0, 7) != 0);
      idex_rd         = 5'($urandom_range(0, 7));
      idex_mem_read   = $urandom_range(0, 1) == 1;
      idex_valid      = ($urandom_range(0, 7) != 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      ex_target       = $urandom;
      ex_muldiv_start = ($urandom_range(0, 9) == 0);
      dmem_busy       = ($urandom_range(0, 7) == 0);
      resetn          = ($urandom_range(0, 199) != 0);
      step();
    end
    resetn = 1'b1;
    idle();

    repeat (4) @(negedge clock);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
